multdiv_sequencer: RTL and testbench

//   Sequences the shared iterative multiply/divide unit for the execute stage of
//   the 5-stage pipeline. Decodes mul/div in the X-stage IR, latches operands,

---
 rtl/multdiv_sequencer.sv | 132 +++++++++++++
 tb/tb_multdiv_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer
//   Sequences the shared iterative multiply/divide unit for the execute (X)
//   stage. A mul/div seen in X has its operands latched and gets a one-cycle
//   start pulse. The pipeline is stalled until the unit reports ready or a
//   watchdog expires. The captured result and the rstatus code are then
//   presented for exactly one cycle (DONE), while the instruction leaves X.
//
// Ports
//   clock, reset             rising-edge clock, asynchronous active-high reset
//   ex_ir, op_a, op_b, flush X-stage instruction, bypassed operands, squash
//   md_start_mult/div        one-cycle start pulses to the unit
//   md_op_a, md_op_b         operands held stable for the unit
//   md_result, md_exception  unit result and error flag, valid with md_ready
//   md_ready                 unit completion pulse
//   stall                    hold PC and the F/D, D/X, X/M latches
//   result, result_valid     captured result (0 on timeout), one-cycle valid
//   exception, status_value  rstatus write request and its code
module multdiv_sequencer #(
  parameter int          MAX_CYCLES = 40,
  parameter logic [31:0] STATUS_MUL = 32'd4,
  parameter logic [31:0] STATUS_DIV = 32'd5,
  parameter logic [31:0] STATUS_TMO = 32'd6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ex_ir,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        md_start_mult,
  output logic        md_start_div,
  output logic [31:0] md_op_a,
  output logic [31:0] md_op_b,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        stall,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        exception,
  output logic [31:0] status_value
);

  localparam int CNT_W = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] BUSY = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic             kind_mul;
  logic             is_mul;
  logic             is_div;
  logic             is_md;
  logic             accept;

  always_comb begin
    is_mul = (ex_ir[31:27] == 5'b00000) && (ex_ir[6:2] == 5'b00110);
    is_div = (ex_ir[31:27] == 5'b00000) && (ex_ir[6:2] == 5'b00111);
    is_md  = is_mul | is_div;
    accept = (state == IDLE) && is_md && !flush;
  end

  // The stall must rise in the same cycle the mul/div is decoded, so it is
  // combinational; it is low in DONE so the instruction advances with result.
  assign stall        = accept || (state == BUSY);
  assign result_valid = (state == DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      kind_mul      <= 1'b0;
      md_start_mult <= 1'b0;
      md_start_div  <= 1'b0;
      md_op_a       <= '0;
      md_op_b       <= '0;
      result        <= '0;
      exception     <= 1'b0;
      status_value  <= '0;
    end else begin
      // Start pulses are registered, so they appear in the first BUSY cycle
      // and can only ever be produced by an IDLE acceptance.
      md_start_mult <= accept && is_mul;
      md_start_div  <= accept && is_div;

      case (state)
        IDLE: begin
          if (accept) begin
            md_op_a  <= op_a;
            md_op_b  <= op_b;
            kind_mul <= is_mul;
            count    <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (count != CNT_LAST) begin
            count <= count + 1'b1;
          end
          // A squash abandons the operation; a late md_ready then lands in
          // IDLE where it is ignored. Ready is checked before the watchdog
          // so a completion on the limit cycle is not reported as timeout.
          if (flush) begin
            state <= IDLE;
          end else if (md_ready) begin
            result       <= md_result;
            exception    <= md_exception;
            status_value <= kind_mul ? STATUS_MUL : STATUS_DIV;
            state        <= DONE;
          end else if (count == CNT_LAST) begin
            result       <= '0;
            exception    <= 1'b1;
            status_value <= STATUS_TMO;
            state        <= DONE;
          end
        end
        DONE: begin
          exception    <= 1'b0;
          status_value <= '0;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer
//   Randomized and directed stimulus for multdiv_sequencer. The driver models
//   the iterative unit (product/quotient, overflow/div-by-zero) and the
//   pipeline (holding the instruction in X while stalled), and pushes the
//   expected start pulse, stall run length and result into queues. A monitor
//   on the falling edge pops and compares whenever the DUT presents them.
module tb_multdiv_sequencer;

  localparam int MAX = 40;

  logic        clock;
  logic        reset;
  logic [31:0] ex_ir;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        md_start_mult;
  logic        md_start_div;
  logic [31:0] md_op_a;
  logic [31:0] md_op_b;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_ready;
  logic        stall;
  logic [31:0] result;
  logic        result_valid;
  logic        exception;
  logic [31:0] status_value;

  multdiv_sequencer #(
    .MAX_CYCLES(MAX),
    .STATUS_MUL(32'd4),
    .STATUS_DIV(32'd5),
    .STATUS_TMO(32'd6)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ex_ir(ex_ir),
    .op_a(op_a),
    .op_b(op_b),
    .flush(flush),
    .md_start_mult(md_start_mult),
    .md_start_div(md_start_div),
    .md_op_a(md_op_a),
    .md_op_b(md_op_b),
    .md_result(md_result),
    .md_exception(md_exception),
    .md_ready(md_ready),
    .stall(stall),
    .result(result),
    .result_valid(result_valid),
    .exception(exception),
    .status_value(status_value)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        exc;
    logic [31:0] st;
    logic [31:0] a;
    logic [31:0] b;
  } res_t;

  typedef struct packed {
    logic        mul;
    logic [31:0] a;
    logic [31:0] b;
  } start_t;

  res_t   rq[$];
  start_t sq[$];
  int     lq[$];

  int n_cmp = 0;
  int n_bad = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] filler();
    logic [31:0] r;
    r = $urandom;
    r[6:2] = 5'b00100;
    return r;
  endfunction

  function automatic logic [31:0] md_instr(input logic mul);
    logic [31:0] r;
    r = $urandom;
    r[31:27] = 5'b00000;
    r[6:2] = mul ? 5'b00110 : 5'b00111;
    return r;
  endfunction

  // Monitor: compares whatever the DUT presents against the queued model.
  start_t ms;
  res_t   mr;
  int     run_len = 0;

  always @(negedge clock) begin
    if (md_start_mult || md_start_div) begin
      if (sq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_start: got mult=%0b div=%0b, expected none", md_start_mult, md_start_div);
      end else begin
        ms = sq.pop_front();
        check("start_kind", {30'b0, md_start_mult, md_start_div}, {30'b0, ms.mul, !ms.mul});
        check("start_op_a", md_op_a, ms.a);
        check("start_op_b", md_op_b, ms.b);
      end
    end

    if (result_valid) begin
      if (rq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result_valid: got result=%h, expected none", result);
      end else begin
        mr = rq.pop_front();
        check("result", result, mr.res);
        check("exception", {31'b0, exception}, {31'b0, mr.exc});
        check("status_value", status_value, mr.st);
        check("held_op_a", md_op_a, mr.a);
        check("held_op_b", md_op_b, mr.b);
      end
    end else begin
      check("quiet_exc_status", status_value | {31'b0, exception}, 32'h0);
    end

    if (stall) begin
      run_len++;
    end else if (run_len > 0) begin
      if (lq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_stall_run: got %0d cycles, expected none", run_len);
      end else begin
        check("stall_run_len", 32'(run_len), 32'(lq.pop_front()));
      end
      run_len = 0;
    end
  end

  // One mul/div through X. ready_at/flush_at are BUSY cycle numbers (1 = the
  // cycle after acceptance, 0 = never). Called at posedge+1.
  task automatic run_op(input logic mul, input logic [31:0] a, input logic [31:0] b,
                        input int ready_at, input int flush_at, input int gap);
    logic [63:0] prod;
    logic [31:0] ures;
    logic        uexc;
    logic [31:0] ir;
    int          lim;
    int          e;
    int          last;
    int          g;
    bit          aborted;
    res_t        r;
    start_t      s;

    if (mul) begin
      prod = {32'b0, a} * {32'b0, b};
      ures = prod[31:0];
      uexc = |prod[63:32];
    end else if (b == 32'h0) begin
      ures = 32'hFFFF_FFFF;
      uexc = 1'b1;
    end else begin
      ures = a / b;
      uexc = 1'b0;
    end

    lim     = (ready_at >= 1 && ready_at <= MAX) ? ready_at : MAX;
    aborted = (flush_at >= 1) && (flush_at < lim);
    e       = aborted ? flush_at : lim + 1;
    last    = (ready_at > e) ? ready_at : e;
    g       = (aborted && gap < 1) ? 1 : gap;

    s.mul = mul; s.a = a; s.b = b;
    sq.push_back(s);
    lq.push_back(aborted ? 1 + flush_at : 1 + lim);
    if (!aborted) begin
      if (ready_at >= 1 && ready_at <= MAX) begin
        r.res = ures; r.exc = uexc; r.st = mul ? 32'd4 : 32'd5;
      end else begin
        r.res = 32'h0; r.exc = 1'b1; r.st = 32'd6;
      end
      r.a = a; r.b = b;
      rq.push_back(r);
    end

    ir = md_instr(mul);
    ex_ir = ir; op_a = a; op_b = b; flush = 1'b0; md_ready = 1'b0;
    @(posedge clock); #1;
    for (int n = 1; n <= last; n++) begin
      ex_ir        = (n <= e) ? ir : filler();
      op_a         = $urandom;
      op_b         = $urandom;
      flush        = (n == flush_at);
      md_ready     = (n == ready_at);
      md_result    = (n == ready_at) ? ures : $urandom;
      md_exception = (n == ready_at) ? uexc : 1'($urandom_range(0, 1));
      @(posedge clock); #1;
    end
    flush = 1'b0; md_ready = 1'b0; ex_ir = filler();
    for (int k = 0; k < g; k++) begin
      @(posedge clock); #1;
    end
  endtask

  // Asynchronous reset in the middle of the third BUSY cycle.
  task automatic reset_op();
    start_t s;
    s.mul = 1'b1; s.a = 32'd21; s.b = 32'd2;
    sq.push_back(s);
    lq.push_back(3);
    ex_ir = md_instr(1'b1); op_a = 32'd21; op_b = 32'd2;
    repeat (3) begin
      @(posedge clock); #1;
    end
    #1 reset = 1'b1; ex_ir = filler();
    #1;
    check("rst_mid_stall", {31'b0, stall}, 32'h0);
    check("rst_mid_start", {30'b0, md_start_mult, md_start_div}, 32'h0);
    check("rst_mid_valid", {31'b0, result_valid}, 32'h0);
    #1 reset = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    int lim;
    int ra;
    int fa;
    logic m;
    logic [31:0] a;
    logic [31:0] b;

    reset = 1'b1; ex_ir = filler(); op_a = 32'h0; op_b = 32'h0; flush = 1'b0;
    md_result = 32'h0; md_exception = 1'b0; md_ready = 1'b0;
    #3;
    check("rst_start", {30'b0, md_start_mult, md_start_div}, 32'h0);
    check("rst_md_op_a", md_op_a, 32'h0);
    check("rst_md_op_b", md_op_b, 32'h0);
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_valid", {31'b0, result_valid}, 32'h0);
    check("rst_exception", {31'b0, exception}, 32'h0);
    check("rst_status", status_value, 32'h0);
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1;

    run_op(1'b1, 32'd7, 32'd6, 32, 0, 1);                 // 7*6, stall 33
    run_op(1'b0, 32'd100, 32'd0, 20, 0, 1);               // divide by zero
    run_op(1'b1, 32'd3, 32'd5, 0, 0, 1);                  // watchdog timeout
    run_op(1'b1, 32'd9, 32'd9, 5, 0, 0);                  // back-to-back mul
    run_op(1'b0, 32'd50, 32'd7, 3, 0, 1);                 //   then div
    run_op(1'b1, 32'd11, 32'd12, 32, 5, 1);               // flush, stale ready
    reset_op();
    run_op(1'b1, 32'd6, 32'd8, 4, 0, 1);                  // normal after reset
    run_op(1'b1, 32'h0001_0000, 32'h0001_0000, MAX, 0, 0); // ready on limit
    run_op(1'b0, 32'd81, 32'd9, MAX + 1, 0, 1);           // ready in DONE
    run_op(1'b1, 32'd2, 32'd3, 4, 5, 1);                  // flush in DONE

    // mul in X squashed while IDLE: must not start or stall
    ex_ir = md_instr(1'b1); flush = 1'b1;
    #1 check("flush_idle_stall", {31'b0, stall}, 32'h0);
    @(posedge clock); #1 flush = 1'b0; ex_ir = filler();
    @(posedge clock); #1;

    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 70000));
      b = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom_range(1, 70000));
      ra = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, MAX + 3);
      lim = (ra >= 1 && ra <= MAX) ? ra : MAX;
      case ($urandom_range(0, 7))
        0, 1: fa = (lim > 1) ? $urandom_range(1, lim - 1) : 0;
        2:    fa = lim + 1;
        default: fa = 0;
      endcase
      run_op(m, a, b, ra, fa, $urandom_range(0, 2));
    end

    repeat (5) begin
      @(posedge clock); #1;
    end
    check("pending_results", 32'(rq.size()), 32'h0);
    check("pending_starts", 32'(sq.size()), 32'h0);
    check("pending_stall_runs", 32'(lq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
